uart_tx_fifo: RTL and testbench

- Byte buffer and launch controller directly upstream of the UART transmitter.
- Game logic pushes bytes at any rate; this block queues them and sends them to the transmitter one at a time.
- Handshake on the transmitter side is start (one-cycle pulse) plus din (8 bits), paced by the transmitter's tx_ready.
- Also provides fill level and a sticky overflow flag for the producer.

---
 rtl/uart_tx_fifo.sv | 114 +++++++++++
 tb/tb_uart_tx_fifo.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte queue in front of the UART transmitter.
// Bytes are stored in a small FIFO. A three-state launcher pops one byte at a
// time into the transmitter using a one-cycle tx_start pulse and a registered
// tx_din, and it waits for tx_ready before each launch.
module uart_tx_fifo #(
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  input  logic              clr_overflow,
  input  logic              tx_ready,
  output logic              tx_start,
  output logic [7:0]        tx_din,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   level,
  output logic              overflow,
  output logic              busy
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ARM  = 2'd1;
  localparam logic [1:0] S_SEND = 2'd2;

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W:0]   count;
  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic              pop_c;
  logic              push_c;
  logic              drop_c;

  // Occupancy decodes; count is the single source of truth.
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign level = count;
  assign busy  = (state != S_IDLE);

  // A push is accepted if there is space, or if a pop frees a slot in the same cycle.
  assign push_c = wr_en & (~full | pop_c);
  assign drop_c = wr_en & ~push_c;

  // Launch FSM. An explicit compare with 1 keeps an unknown tx_ready from launching.
  always_comb begin
    state_nxt = state;
    pop_c     = 1'b0;
    case (state)
      S_IDLE: begin
        if ((count != '0) && (tx_ready == 1'b1)) begin
          pop_c     = 1'b1;
          state_nxt = S_ARM;
        end
      end
      // tx_ready stays high for a short time after start, so wait here until it falls.
      S_ARM: begin
        if (tx_ready == 1'b0) state_nxt = S_SEND;
      end
      S_SEND: begin
        if (tx_ready == 1'b1) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Storage array. It has no reset because contents are qualified by count.
  always_ff @(posedge clk) begin
    if (push_c) mem[wr_ptr] <= wr_data;
  end

  // Pointers, occupancy count and the sticky overflow flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop_c)  rd_ptr <= rd_ptr + ADDR_W'(1);
      case ({push_c, pop_c})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (drop_c)            overflow <= 1'b1;
      else if (clr_overflow) overflow <= 1'b0;
    end
  end

  // Transmitter handshake: one-cycle start pulse, and din held from launch to launch.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_start <= 1'b0;
      tx_din   <= 8'h00;
    end else begin
      tx_start <= pop_c;
      if (pop_c) tx_din <= mem[rd_ptr];
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo. Bytes are checked against hand-computed values,
// and a simple transmitter model drives tx_ready.
module tb_uart_tx_fifo;

  localparam int unsigned ADDR_W = 4;
  localparam int          FRAME  = 11;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              wr_en;
  logic [7:0]        wr_data;
  logic              clr_overflow;
  logic              tx_ready;
  logic              tx_start;
  logic [7:0]        tx_din;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   level;
  logic              overflow;
  logic              busy;

  logic man_rdy;
  logic model_en;
  logic model_rdy = 1'b1;
  int   hold = 0;
  int   low  = 0;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] rx_q[$];
  int         pulse_cyc[$];
  int         cyc = 0;
  int         bad_launch = 0;
  logic       rdy_at_edge = 1'b1;
  int         base;

  uart_tx_fifo #(.ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .clr_overflow (clr_overflow),
    .tx_ready     (tx_ready),
    .tx_start     (tx_start),
    .tx_din       (tx_din),
    .full         (full),
    .empty        (empty),
    .level        (level),
    .overflow     (overflow),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  assign tx_ready = model_en ? model_rdy : man_rdy;

  // Transmitter model: ready stays high for two edges after start, then low for a frame.
  always @(negedge clk) begin
    if (!model_en) begin
      hold = 0;
      low = 0;
      model_rdy = 1'b1;
    end else if (tx_start === 1'b1) begin
      hold = 1;
      low = FRAME;
    end else if (hold > 0) begin
      hold = hold - 1;
    end else if (low > 0) begin
      low = low - 1;
      model_rdy = (low == 0);
    end
  end

  always @(posedge clk) rdy_at_edge <= tx_ready;

  // Record every launched byte and the cycle it was launched in.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (tx_start === 1'b1) begin
      rx_q.push_back(tx_din);
      pulse_cyc.push_back(cyc);
      if (rdy_at_edge !== 1'b1) bad_launch = bad_launch + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [7:0] b);
    wr_en = 1'b1;
    wr_data = b;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic wait_sent(input string tag, input int n, input int budget);
    int k;
    k = 0;
    while ((rx_q.size() < n || busy !== 1'b0) && k < budget) begin
      tick();
      k++;
    end
    check(tag, 32'(rx_q.size()), 32'(n));
  endtask

  initial begin
    reset_n = 1'b0;
    wr_en = 1'b0;
    wr_data = 8'h00;
    clr_overflow = 1'b0;
    man_rdy = 1'b1;
    model_en = 1'b0;
    tick(2);

    check("rst_full",     32'(full),     32'd0);
    check("rst_empty",    32'(empty),    32'd1);
    check("rst_level",    32'(level),    32'd0);
    check("rst_busy",     32'(busy),     32'd0);
    check("rst_tx_start", 32'(tx_start), 32'd0);
    check("rst_tx_din",   32'(tx_din),   32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    reset_n = 1'b1;
    tick();

    // Single byte with manual tx_ready control
    push(8'hA5);
    check("single_no_early", 32'(tx_start), 32'd0);
    check("single_level1",   32'(level),    32'd1);
    tick();
    check("single_start",  32'(tx_start), 32'd1);
    check("single_din",    32'(tx_din),   32'hA5);
    check("single_level0", 32'(level),    32'd0);
    check("single_busy",   32'(busy),     32'd1);
    tick();
    check("single_pulse1cyc", 32'(tx_start), 32'd0);
    check("single_arm_busy",  32'(busy),     32'd1);
    man_rdy = 1'b0;
    tick(2);
    check("single_send_busy", 32'(busy),   32'd1);
    check("single_din_held",  32'(tx_din), 32'hA5);
    man_rdy = 1'b1;
    tick();
    check("single_idle",   32'(busy),        32'd0);
    check("single_npulse", 32'(rx_q.size()), 32'd1);
    check("single_empty",  32'(empty),       32'd1);

    // Burst of five bytes through the transmitter model
    model_en = 1'b1;
    base = rx_q.size();
    for (int i = 1; i <= 5; i++) push(8'(i));
    check("burst_level", 32'(level), 32'd4);
    wait_sent("burst_count", base + 5, 300);
    for (int i = 0; i < 5; i++) check("burst_byte", 32'(rx_q[base + i]), 32'(i + 1));
    for (int i = 1; i < 5; i++)
      check("burst_gap", 32'(pulse_cyc[base + i] - pulse_cyc[base + i - 1]), 32'd14);
    check("burst_level_end", 32'(level), 32'd0);

    // Fill to full, then overflow and clear
    model_en = 1'b0;
    man_rdy = 1'b0;
    tick();
    for (int i = 0; i < 16; i++) push(8'(8'h10 + i));
    check("full_flag",   32'(full),     32'd1);
    check("full_level",  32'(level),    32'd16);
    check("full_no_ovf", 32'(overflow), 32'd0);
    push(8'hEE);
    check("ovf_set",   32'(overflow), 32'd1);
    check("ovf_level", 32'(level),    32'd16);
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    check("ovf_clear", 32'(overflow), 32'd0);

    // Push and pop in the same cycle while full
    base = rx_q.size();
    model_en = 1'b1;
    wr_en = 1'b1;
    wr_data = 8'h2F;
    tick();
    wr_en = 1'b0;
    check("pp_start", 32'(tx_start), 32'd1);
    check("pp_din",   32'(tx_din),   32'h10);
    check("pp_level", 32'(level),    32'd16);
    check("pp_ovf",   32'(overflow), 32'd0);
    wait_sent("pp_count", base + 17, 500);
    for (int i = 0; i < 16; i++) check("full_order", 32'(rx_q[base + i]), 32'(8'h10 + i));
    check("pp_last", 32'(rx_q[base + 16]), 32'h2F);

    // Send 40 bytes through the FIFO so that both pointers wrap
    base = rx_q.size();
    for (int i = 0; i < 40; i++) begin
      int k;
      k = 0;
      while (full === 1'b1 && k < 100) begin
        tick();
        k++;
      end
      push(8'(8'h40 + i));
    end
    wait_sent("wrap_count", base + 40, 1000);
    for (int i = 0; i < 40; i++) check("wrap_byte", 32'(rx_q[base + i]), 32'(8'h40 + i));
    check("wrap_ovf",   32'(overflow),   32'd0);
    check("no_bad_launch", 32'(bad_launch), 32'd0);

    // Asynchronous reset in SEND with three bytes still queued
    model_en = 1'b0;
    man_rdy = 1'b1;
    tick();
    push(8'hC1);
    push(8'hC2);
    push(8'hC3);
    push(8'hC4);
    man_rdy = 1'b0;
    tick();
    check("rs_busy",  32'(busy),   32'd1);
    check("rs_level", 32'(level),  32'd3);
    check("rs_din",   32'(tx_din), 32'hC1);
    #2 reset_n = 1'b0;
    #1;
    check("rs_start0", 32'(tx_start), 32'd0);
    check("rs_empty",  32'(empty),    32'd1);
    check("rs_level0", 32'(level),    32'd0);
    check("rs_busy0",  32'(busy),     32'd0);
    man_rdy = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    base = rx_q.size();
    tick(10);
    check("rs_no_launch", 32'(rx_q.size()), 32'(base));
    check("rs_empty_end", 32'(empty),       32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
